dom_rand_gen_gf4_paired: RTL and testbench
==========================================

# dom_rand_gen_gf4_paired

Fresh-randomness source for the paired DOM GF(4) multipliers in the masked AES S-box. It expands a seed into per-cycle remask words `Z1`, `Z2` and blinding word `B`, with widths that match the paired multiplier's `_Z1xDI`, `_Z2xDI` and `_BxDI` inputs. It sits on the producer side of those ports and advances only when the masked pipeline advances. The randomness comes from a bank of 32-bit LFSR lanes, and a seed/warm-up handshake guarantees that no stale or zero words are flagged valid.

## Interface
- `SHARES`, 2: share count; must equal the consumer's `SHARES`.
- `FIRST_ORDER_OPTIMIZATION`, 1: selects `B` width through `_blind_nrnd(SHARES)` from `blind.vh`, identical to the consumer.
- `WARMUP_CYCLES`, 16: number of lane advances after seeding before output is valid; minimum 1.
- Derived width `RZ` = 2\*SHARES\*(SHARES-1).
- Derived width `RB` = 4\*_blind_nrnd(SHARES).
- Derived width `R` = 2\*RZ + RB.
- Derived lane count `NLANE` = ceil(R/32).
- `ClkxCI` in 1: clock; all state updates on the rising edge.
- `RstxBI` in 1: asynchronous, active-low reset.
- `SeedxDI` in 32\*NLANE: seed; lane i takes bits [32i+31:32i].
- `SeedValidxSI` in 1: load `SeedxDI` on this edge; accepted in any state except ERROR.
- `EnablexSI` in 1: consumer pipeline advance; in RUN, advances all lanes.
- `_Z1xDO` out RZ: remask word for multiplier 1.
- `_Z2xDO` out RZ: remask word for multiplier 2.
- `_BxDO` out RB: blinding word.
- `ValidxSO` out 1: words are fresh and usable.
- `ErrorxSO` out 1: sticky; a lane reached the all-zero state.

## Operation
- Lane: 32-bit Fibonacci LFSR with polynomial x^32+x^22+x^2+x+1. One "advance" means 32 single-bit steps unrolled combinationally, so every state bit is renewed on each advance.
- Output vector `V` = {lane NLANE-1, …, lane 0} truncated to R bits:
  - `_BxDO` = V[RB-1:0]
  - `_Z1xDO` = V[RB+RZ-1:RB]
  - `_Z2xDO` = V[R-1:RB+RZ]
- When `ValidxSO`=0, all three data outputs are forced to 0.
- Seed load: a zero lane seed is replaced by 32'h0000_0001. The warm-up counter loads WARMUP_CYCLES-1.
- State machine (registered state), with transitions:
  - IDLE: wait for seed. `SeedValidxSI` → WARMUP.
  - WARMUP: lanes advance every edge, ignoring `EnablexSI`. Counter 0 → RUN and set `ValidxSO`; otherwise decrement the counter. `SeedValidxSI` → reload the seed and counter, stay in WARMUP.
  - RUN: `EnablexSI`=1 → all lanes advance; `EnablexSI`=0 → hold. `SeedValidxSI` → reload, go to WARMUP, clear `ValidxSO`. Reseed has priority over `EnablexSI`.
  - ERROR: entered from RUN or WARMUP when any lane register equals 0 after an update. Sets `ErrorxSO` and clears `ValidxSO`. Left only by reset.
- Reset (asynchronous, any time including mid-warm-up): state IDLE, all lanes 0, counter 0, `ValidxSO`=0, `ErrorxSO`=0, all data outputs 0.

## Timing
- All outputs are registered or derived from registers; there is no combinational input-to-output path.
- Seed accepted at edge e0 → `ValidxSO` rises at edge e0+WARMUP_CYCLES, showing the state after WARMUP_CYCLES advances.
- In RUN, `EnablexSI`=1 sampled at edge e → new words are visible after e. The consumer uses the words present before e for that edge's register update.
- Reseed in RUN at edge e → `ValidxSO`=0 after e and stays low for WARMUP_CYCLES edges.
- A reset deassertion that coincides with `SeedValidxSI` leaves the block in IDLE; the seed must be reasserted.

## Structure
- Package `dom_rand_pkg` holds:
  - lane width 32, tap positions {32,22,2,1}, zero-seed substitute constant;
  - state encoding IDLE/WARMUP/RUN/ERROR;
  - width functions for RZ, RB, R and NLANE, wrapping `_blind_nrnd`.
- Sub-module `lfsr32_adv32`: combinational 32-step advance of one lane, instantiated NLANE times.
- The top level holds lane registers, counter, FSM, output slicing and zero-forcing.

## Test plan
- Reset release, no seed, 50 cycles with `EnablexSI`=1 → `ValidxSO`=0 and all outputs 0 throughout.
- `WARMUP_CYCLES`=4, seed lane0=32'hDEAD_BEEF at edge 10 → `ValidxSO` rises at edge 14. With `SHARES`=2, `_BxDO` width 4, `_Z1xDO`/`_Z2xDO` width 4, and values match a golden 4-advance model.
- In RUN, hold `EnablexSI`=0 for 5 cycles → outputs constant. Then toggle 1,0,1 → exactly two new words, each matching the golden model.
- Two runs seeded with 32'h0 and with 32'h1 → bit-identical output sequences over 100 words.
- Reseed in RUN at edge 30 while `EnablexSI`=1 → `ValidxSO` low after edge 30, high again at edge 30+WARMUP_CYCLES, sequence restarts from the new seed. Assert `RstxBI` mid-warm-up → outputs 0 immediately, state IDLE.
- Force lane 0 to zero via testbench → `ErrorxSO`=1 on the next edge, `ValidxSO`=0, outputs 0, a new seed is ignored until reset.

Source files
------------

// File: rtl/dom_rand_pkg.sv
// Shared definitions for the DOM GF(4) fresh-randomness generator.
// Holds the LFSR lane geometry, the zero-seed substitute, the control state
// encoding and the width functions that size the Z1/Z2/B output words so
// they line up with the paired GF(4) multiplier inputs.
package dom_rand_pkg;

  localparam int LANE_W = 32;

  // Feedback taps of x^32 + x^22 + x^2 + x + 1, as 1-based polynomial exponents
  localparam int TAP_A = 32;
  localparam int TAP_B = 22;
  localparam int TAP_C = 2;
  localparam int TAP_D = 1;

  // An all-zero LFSR state never leaves zero, so a zero seed is replaced
  localparam logic [LANE_W-1:0] ZERO_SEED_SUB = 32'h0000_0001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2,
    ERROR  = 2'd3
  } state_t;

  // Blinding randomness count of the paired multiplier (mirrors _blind_nrnd)
  function automatic int blindNrnd(input int shares, input int firstOrderOpt);
    if (shares < 2) return 0;
    if ((firstOrderOpt != 0) && (shares == 2)) return 1;
    return shares * (shares - 1);
  endfunction

  function automatic int rzWidth(input int shares);
    return 2 * shares * (shares - 1);
  endfunction

  function automatic int rbWidth(input int shares, input int firstOrderOpt);
    return 4 * blindNrnd(shares, firstOrderOpt);
  endfunction

  function automatic int rWidth(input int shares, input int firstOrderOpt);
    return 2 * rzWidth(shares) + rbWidth(shares, firstOrderOpt);
  endfunction

  function automatic int nLane(input int shares, input int firstOrderOpt);
    return (rWidth(shares, firstOrderOpt) + LANE_W - 1) / LANE_W;
  endfunction

endpackage

// File: rtl/lfsr32_adv32.sv
// One lane advance: 32 Fibonacci LFSR steps of x^32+x^22+x^2+x+1 unrolled
// combinationally, so every state bit is replaced on each advance.
// Ports:
//   StatexDI  current 32-bit lane state
//   StatexDO  lane state after 32 single-bit steps
module lfsr32_adv32
  import dom_rand_pkg::*;
(
  input  logic [LANE_W-1:0] StatexDI,
  output logic [LANE_W-1:0] StatexDO
);

  logic [LANE_W-1:0] stepxD;

  always_comb begin
    stepxD = StatexDI;
    // Newest bit enters at bit 0; bit k was inserted k steps ago
    for (int k = 0; k < LANE_W; k++) begin
      stepxD = {stepxD[LANE_W-2:0],
                stepxD[TAP_A-1] ^ stepxD[TAP_B-1] ^ stepxD[TAP_C-1] ^ stepxD[TAP_D-1]};
    end
    StatexDO = stepxD;
  end

endmodule

// File: rtl/dom_rand_gen_gf4_paired.sv
// Fresh-randomness source for the paired DOM GF(4) multipliers.
// A bank of NLANE 32-bit LFSR lanes is seeded, warmed up for WARMUP_CYCLES
// advances and then advanced only when the consumer pipeline advances.
// Ports:
//   ClkxCI        clock, rising edge
//   RstxBI        asynchronous active-low reset
//   SeedxDI       seed, lane i takes bits [32i+31:32i]
//   SeedValidxSI  load seed (ignored in ERROR)
//   EnablexSI     consumer advance; advances lanes while in RUN
//   _Z1xDO        remask word for multiplier 1
//   _Z2xDO        remask word for multiplier 2
//   _BxDO         blinding word
//   ValidxSO      words are fresh and usable
//   ErrorxSO      sticky: a lane reached the all-zero state
module dom_rand_gen_gf4_paired
  import dom_rand_pkg::*;
#(
  parameter int SHARES                   = 2,
  parameter int FIRST_ORDER_OPTIMIZATION = 1,
  parameter int WARMUP_CYCLES            = 16,
  localparam int RZ    = rzWidth(SHARES),
  localparam int RB    = rbWidth(SHARES, FIRST_ORDER_OPTIMIZATION),
  localparam int R     = rWidth(SHARES, FIRST_ORDER_OPTIMIZATION),
  localparam int NLANE = nLane(SHARES, FIRST_ORDER_OPTIMIZATION)
) (
  input  logic                    ClkxCI,
  input  logic                    RstxBI,
  input  logic [LANE_W*NLANE-1:0] SeedxDI,
  input  logic                    SeedValidxSI,
  input  logic                    EnablexSI,
  output logic [RZ-1:0]           _Z1xDO,
  output logic [RZ-1:0]           _Z2xDO,
  output logic [RB-1:0]           _BxDO,
  output logic                    ValidxSO,
  output logic                    ErrorxSO
);

  localparam int CNT_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WARMUP_CYCLES - 1);

  logic [LANE_W*NLANE-1:0] lanexDP, lanexDN;
  logic [LANE_W*NLANE-1:0] advxD;
  logic [LANE_W*NLANE-1:0] seedSubxD;
  logic [CNT_W-1:0]        cntxDP, cntxDN;
  state_t                  statexDP, statexDN;
  logic                    anyZeroxS;
  logic [R-1:0]            vecxD;

  for (genvar i = 0; i < NLANE; i++) begin : g_lane
    lfsr32_adv32 u_adv (
      .StatexDI (lanexDP[LANE_W*i +: LANE_W]),
      .StatexDO (advxD[LANE_W*i +: LANE_W])
    );

    assign seedSubxD[LANE_W*i +: LANE_W] =
      (SeedxDI[LANE_W*i +: LANE_W] == '0) ? ZERO_SEED_SUB : SeedxDI[LANE_W*i +: LANE_W];
  end

  always_comb begin
    statexDN  = statexDP;
    lanexDN   = lanexDP;
    cntxDN    = cntxDP;
    anyZeroxS = 1'b0;

    case (statexDP)
      IDLE: begin
        if (SeedValidxSI) begin
          lanexDN  = seedSubxD;
          cntxDN   = CNT_LOAD;
          statexDN = WARMUP;
        end
      end
      WARMUP: begin
        if (SeedValidxSI) begin
          lanexDN = seedSubxD;
          cntxDN  = CNT_LOAD;
        end else begin
          lanexDN = advxD;
          if (cntxDP == '0) statexDN = RUN;
          else              cntxDN   = cntxDP - CNT_W'(1);
        end
      end
      RUN: begin
        if (SeedValidxSI) begin
          lanexDN  = seedSubxD;
          cntxDN   = CNT_LOAD;
          statexDN = WARMUP;
        end else if (EnablexSI) begin
          lanexDN = advxD;
        end
      end
      ERROR: ;
      default: statexDN = IDLE;
    endcase

    // A lane that would hold zero after this edge can never recover
    if ((statexDP == WARMUP) || (statexDP == RUN)) begin
      for (int l = 0; l < NLANE; l++) begin
        if (lanexDN[LANE_W*l +: LANE_W] == '0) anyZeroxS = 1'b1;
      end
      if (anyZeroxS) statexDN = ERROR;
    end
  end

  // ---- register stage: lanes, warm-up counter, control state ----
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      statexDP <= IDLE;
      lanexDP  <= '0;
      cntxDP   <= '0;
    end else begin
      statexDP <= statexDN;
      lanexDP  <= lanexDN;
      cntxDP   <= cntxDN;
    end
  end

  // ---- output stage: status decode, slicing, zero-forcing ----
  assign ValidxSO = (statexDP == RUN);
  assign ErrorxSO = (statexDP == ERROR);

  assign vecxD  = lanexDP[R-1:0] & {R{ValidxSO}};
  assign _BxDO  = vecxD[RB-1:0];
  assign _Z1xDO = vecxD[RB+RZ-1:RB];
  assign _Z2xDO = vecxD[R-1:RB+RZ];

endmodule

// File: tb/tb_dom_rand_gen_gf4_paired.sv
// Randomized scoreboard bench for dom_rand_gen_gf4_paired with SHARES=2,
// FIRST_ORDER_OPTIMIZATION=1, WARMUP_CYCLES=4 (B, Z1, Z2 are 4 bits each).
// The reference model produces lane words from the LFSR bit recurrence
// a[n] = a[n-32]^a[n-22]^a[n-2]^a[n-1] and counts warm-up advances.
module tb_dom_rand_gen_gf4_paired;

  localparam int W  = 4;
  localparam int RZ = 4;
  localparam int RB = 4;

  logic          ClkxCI = 1'b0;
  logic          RstxBI = 1'b0;
  logic [31:0]   SeedxDI = '0;
  logic          SeedValidxSI = 1'b0;
  logic          EnablexSI = 1'b0;
  logic [RZ-1:0] z1, z2;
  logic [RB-1:0] b;
  logic          vld, err;

  dom_rand_gen_gf4_paired #(
    .SHARES(2), .FIRST_ORDER_OPTIMIZATION(1), .WARMUP_CYCLES(W)
  ) dut (
    .ClkxCI       (ClkxCI),
    .RstxBI       (RstxBI),
    .SeedxDI      (SeedxDI),
    .SeedValidxSI (SeedValidxSI),
    .EnablexSI    (EnablexSI),
    ._Z1xDO       (z1),
    ._Z2xDO       (z2),
    ._BxDO        (b),
    .ValidxSO     (vld),
    .ErrorxSO     (err)
  );

  always #5 ClkxCI = ~ClkxCI;

  typedef struct packed {
    logic          vld;
    logic          err;
    logic [RZ-1:0] z2;
    logic [RZ-1:0] z1;
    logic [RB-1:0] b;
  } exp_t;

  exp_t expQ[$];
  int   nVec = 0;
  int   nMis = 0;

  // ---------------- reference model ----------------
  typedef enum int {MIdle, MWarm, MRun, MErr} mmode_t;
  mmode_t      mMode = MIdle;
  logic [31:0] mLane = '0;
  int          mDone = 0;

  // Bit k of the lane word is the bit produced k steps ago.
  function automatic logic [31:0] advanceLane(input logic [31:0] s);
    bit hist[$];
    logic [31:0] r;
    for (int k = 31; k >= 0; k--) hist.push_back(s[k]);
    for (int n = 0; n < 32; n++) begin
      int sz;
      sz = hist.size();
      hist.push_back(hist[sz-32] ^ hist[sz-22] ^ hist[sz-2] ^ hist[sz-1]);
    end
    for (int k = 0; k < 32; k++) r[k] = hist[hist.size()-1-k];
    return r;
  endfunction

  task automatic modelEdge(input logic sv, input logic en, input logic fz,
                           input logic [31:0] seed);
    if (mMode == MErr) begin
    end else if (fz && (mMode == MRun || mMode == MWarm)) begin
      mLane = '0;
      mMode = MErr;
    end else if (sv) begin
      mLane = (seed == 32'h0) ? 32'h1 : seed;
      mMode = MWarm;
      mDone = 0;
    end else if (mMode == MWarm) begin
      mLane = advanceLane(mLane);
      mDone++;
      if (mDone == W) mMode = MRun;
    end else if (mMode == MRun && en) begin
      mLane = advanceLane(mLane);
    end
  endtask

  function automatic exp_t expNow();
    exp_t e;
    logic ok;
    ok    = (mMode == MRun);
    e.vld = ok;
    e.err = (mMode == MErr);
    e.b   = ok ? mLane[3:0]  : '0;
    e.z1  = ok ? mLane[7:4]  : '0;
    e.z2  = ok ? mLane[11:8] : '0;
    return e;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    forever begin
      exp_t e, a;
      @(posedge ClkxCI);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        a = {vld, err, z2, z1, b};
        nVec++;
        if (a !== e) begin
          nMis++;
          $display("FAIL word@%0t: got vld=%b err=%b z2=%h z1=%h b=%h, expected vld=%b err=%b z2=%h z1=%h b=%h",
                   $time, a.vld, a.err, a.z2, a.z1, a.b, e.vld, e.err, e.z2, e.z1, e.b);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle(input logic sv, input logic en, input logic [31:0] seed,
                       input logic fz);
    @(negedge ClkxCI);
    SeedValidxSI = sv;
    EnablexSI    = en;
    SeedxDI      = seed;
    if (fz) force dut.lanexDP = '0;
    modelEdge(sv, en, fz, seed);
    expQ.push_back(expNow());
    @(posedge ClkxCI);
    #2;
    if (fz) release dut.lanexDP;
  endtask

  task automatic checkNow(input string name);
    exp_t a;
    a = {vld, err, z2, z1, b};
    nVec++;
    if (a !== exp_t'(0)) begin
      nMis++;
      $display("FAIL %s: got vld=%b err=%b z2=%h z1=%h b=%h, expected all zero",
               name, a.vld, a.err, a.z2, a.z1, a.b);
    end
  endtask

  task automatic doReset(input string name);
    @(negedge ClkxCI);
    RstxBI       = 1'b0;
    SeedValidxSI = 1'b0;
    EnablexSI    = 1'b0;
    #1;
    checkNow(name);
    mMode = MIdle;
    mLane = '0;
    mDone = 0;
    @(negedge ClkxCI);
    @(negedge ClkxCI);
    RstxBI = 1'b1;
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge ClkxCI);
    #1;
    checkNow("reset_state");
    RstxBI = 1'b1;

    // no seed: must stay idle with zero outputs
    for (int i = 0; i < 50; i++) cycle(1'b0, 1'b1, $urandom, 1'b0);

    // golden seed, warm-up ignores enable
    cycle(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0);
    for (int i = 0; i < W + 2; i++) cycle(1'b0, 1'($urandom_range(0, 1)), '0, 1'b0);

    // hold, then 1,0,1
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b1, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b1, '0, 1'b0);

    // random enables in RUN
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'($urandom_range(0, 1)), '0, 1'b0);

    // reseed in RUN while enabled (reseed wins)
    cycle(1'b1, 1'b1, $urandom, 1'b0);
    for (int i = 0; i < W + 6; i++) cycle(1'b0, 1'b1, '0, 1'b0);

    // reseed, then reset mid-warm-up
    cycle(1'b1, 1'b1, $urandom, 1'b0);
    cycle(1'b0, 1'b1, '0, 1'b0);
    doReset("reset_mid_warmup");
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, '0, 1'b0);

    // zero seed behaves as seed 1
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < W + 100; i++) cycle(1'b0, 1'b1, '0, 1'b0);
    doReset("reset_between_runs");
    cycle(1'b1, 1'b0, 32'h1, 1'b0);
    for (int i = 0; i < W + 100; i++) cycle(1'b0, 1'b1, '0, 1'b0);

    // random phase with occasional reseeds
    for (int i = 0; i < 200; i++) begin
      logic sv;
      sv = ($urandom_range(0, 99) < 4);
      cycle(sv, 1'($urandom_range(0, 1)), $urandom, 1'b0);
    end

    // make sure we are in RUN, then force a zero lane
    cycle(1'b1, 1'b0, 32'h1234_5678, 1'b0);
    for (int i = 0; i < W + 2; i++) cycle(1'b0, 1'b1, '0, 1'b0);
    cycle(1'b0, 1'b1, '0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, $urandom, 1'b0);

    // only reset leaves ERROR
    doReset("reset_from_error");
    cycle(1'b1, 1'b0, 32'hCAFE_F00D, 1'b0);
    for (int i = 0; i < W + 8; i++) cycle(1'b0, 1'($urandom_range(0, 1)), '0, 1'b0);

    @(posedge ClkxCI);
    #3;
    if (expQ.size() != 0) begin
      nVec++;
      nMis++;
      $display("FAIL drain: got %0d pending words, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
